lock_bank_ctrl: RTL

Sequencing controller for a lockable 4-entry register bank shared by multiple requesters. Arbitrates write requests round-robin, enforces one sticky lock bit per entry so every entry is protected by exactly its own lock, writes the bank, and returns a per-request completion/error response. Sits between bus-side requesters and the bank storage it owns.

---
 rtl/lock_bank_pkg.sv | 13 +
 rtl/lock_bank_ctrl_rr_arbiter.sv | 29 ++
 rtl/lock_bank_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/lock_bank_pkg.sv
// Shared types and constants for the lockable register-bank controller.
package lock_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int ERRCNT_W = 8;

endpackage

// File: rtl/lock_bank_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past last_grant.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    int  idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/lock_bank_ctrl.sv
// Arbitrates requester writes into a 4-entry bank guarded by sticky per-entry locks.
// Handshake: a requester holds req_valid/addr/wdata stable until its req_ready pulse; rsp_valid/rsp_err pulse once per accepted request.
module lock_bank_ctrl
  import lock_bank_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int N_ENTRIES = 4,
  parameter  int N_REQ     = 2,
  localparam int ADDR_W    = $clog2(N_ENTRIES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_W-1:0]     req_addr,
  input  logic [N_REQ*DATA_W-1:0]     req_wdata,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic                        rsp_err,
  input  logic [N_ENTRIES-1:0]        lock_set,
  output logic [N_ENTRIES-1:0]        lock_status,
  output logic [N_ENTRIES*DATA_W-1:0] bank,
  output logic [ERRCNT_W-1:0]         err_count,
  output state_e                      state_dbg
);

  localparam int GIDX_W = $clog2(N_REQ);

  state_e                state_q, state_d;
  logic [N_REQ-1:0]      grant;
  logic [GIDX_W-1:0]     grant_idx, last_grant_q, gnt_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  err_q;
  logic                  locked;
  logic [ERRCNT_W-1:0]   err_count_q;
  logic [N_ENTRIES-1:0]  lock_q;
  logic [DATA_W-1:0]     bank_q [N_ENTRIES];

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // A lock arriving in the same cycle as the check already refuses the write.
  assign locked = lock_q[addr_q] | lock_set[addr_q];

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    rsp_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = grant;
          state_d   = CHECK;
        end
      end
      CHECK: state_d = locked ? RESP : WRITE;
      WRITE: state_d = RESP;
      RESP: begin
        rsp_valid = N_REQ'(1) << gnt_q;
        rsp_err   = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GIDX_W'(N_REQ - 1);
      gnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
      lock_q       <= '0;
      for (int e = 0; e < N_ENTRIES; e++) bank_q[e] <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_q | lock_set;
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            last_grant_q <= grant_idx;
            gnt_q        <= grant_idx;
            addr_q       <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
            wdata_q      <= req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
            err_q        <= 1'b0;
          end
        end
        CHECK: err_q <= locked;
        WRITE: bank_q[addr_q] <= wdata_q;
        RESP: begin
          if (err_q && (err_count_q != '1)) err_count_q <= err_count_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bank = '0;
    for (int e = 0; e < N_ENTRIES; e++) bank[e*DATA_W +: DATA_W] = bank_q[e];
  end

  assign lock_status = lock_q;
  assign err_count   = err_count_q;
  assign state_dbg   = state_q;

endmodule
